// File: rtl/demux_bh.sv
// Registered 2-to-4 demultiplexer: {b,a} selects one output line when en is high.
// ACTIVE_LOW inverts every output value, reset included.
module demux_bh #(
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       a,
  input  logic       b,
  input  logic       en,
  output logic [3:0] z
);

  localparam logic [3:0] INACTIVE = ACTIVE_LOW ? 4'b1111 : 4'b0000;

  logic [3:0] onehot;
  logic [3:0] z_d;
  logic [3:0] z_q;

  always_comb begin
    onehot = 4'b0000;
    // NOTE: every comb output gets a default first, so no path can infer a latch.
    // An X or Z on any select/enable bit matches no item and falls to the all-inactive default.
    case ({en, b, a})
      3'b100:  onehot = 4'b0001;
      3'b101:  onehot = 4'b0010;
      3'b110:  onehot = 4'b0100;
      3'b111:  onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    z_d = ACTIVE_LOW ? ~onehot : onehot;
  end

  // NOTE: state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      z_q <= INACTIVE;
    end else begin
      z_q <= z_d;
    end
  end

  assign z = z_q;

endmodule

// File: tb/tb_demux_bh.sv
// Directed bench for demux_bh: one instance per polarity, both fed the same inputs.
module tb_demux_bh;

  logic       clk;
  logic       rst_n;
  logic       a;
  logic       b;
  logic       en;
  logic [3:0] z0;
  logic [3:0] z1;

  int errors = 0;
  int checks = 0;

  demux_bh #(.ACTIVE_LOW(1'b0)) dut_hi (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en), .z(z0)
  );

  demux_bh #(.ACTIVE_LOW(1'b1)) dut_lo (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .en(en), .z(z1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Advance to just after the next rising edge, where outputs are stable.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    en = 1'b1;
    a = 1'b1;
    b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (z0 !== 4'b0000) begin
        errors++;
        $display("FAIL reset_hi cycle %0d: got %b want 0000", i, z0);
      end
      checks++;
      if (z1 !== 4'b1111) begin
        errors++;
        $display("FAIL reset_lo cycle %0d: got %b want 1111", i, z1);
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_sweep();
    logic [3:0] exp_tbl [8];
    logic [2:0] vec;
    exp_tbl = '{4'b0000, 4'b0001, 4'b0000, 4'b0010,
                4'b0000, 4'b0100, 4'b0000, 4'b1000};
    for (int i = 0; i < 8; i++) begin
      vec = 3'(i);
      {b, a, en} = vec;
      tick();
      checks++;
      if (z0 !== exp_tbl[i]) begin
        errors++;
        $display("FAIL sweep_hi bae=%b: got %b want %b", vec, z0, exp_tbl[i]);
      end
      checks++;
      if (z1 !== ~exp_tbl[i]) begin
        errors++;
        $display("FAIL sweep_lo bae=%b: got %b want %b", vec, z1, ~exp_tbl[i]);
      end
    end
  endtask

  task automatic test_latency();
    // Sweep left b=1,a=1,en=1 registered, so z0 holds 1000.
    a = 1'b0;
    b = 1'b0;
    en = 1'b1;
    #3;
    checks++;
    if (z0 !== 4'b1000) begin
      errors++;
      $display("FAIL latency_hold: got %b want 1000", z0);
    end
    en = 1'b0;
    #2;
    en = 1'b1;
    checks++;
    if (z0 !== 4'b1000) begin
      errors++;
      $display("FAIL latency_hold2: got %b want 1000", z0);
    end
    tick();
    checks++;
    if (z0 !== 4'b0001) begin
      errors++;
      $display("FAIL latency_update: got %b want 0001", z0);
    end
  endtask

  task automatic test_async_reset();
    en = 1'b1;
    b = 1'b1;
    a = 1'b0;
    tick();
    checks++;
    if (z0 !== 4'b0100) begin
      errors++;
      $display("FAIL areset_pre: got %b want 0100", z0);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (z0 !== 4'b0000) begin
      errors++;
      $display("FAIL areset_immediate_hi: got %b want 0000", z0);
    end
    checks++;
    if (z1 !== 4'b1111) begin
      errors++;
      $display("FAIL areset_immediate_lo: got %b want 1111", z1);
    end
    tick();
    checks++;
    if (z0 !== 4'b0000) begin
      errors++;
      $display("FAIL areset_edge_blocked: got %b want 0000", z0);
    end
    rst_n = 1'b1;
    tick();
    checks++;
    if (z0 !== 4'b0100) begin
      errors++;
      $display("FAIL areset_resume: got %b want 0100", z0);
    end
  endtask

  task automatic test_active_low();
    en = 1'b1;
    b = 1'b0;
    a = 1'b1;
    tick();
    checks++;
    if (z1 !== 4'b1101) begin
      errors++;
      $display("FAIL active_low_sel1: got %b want 1101", z1);
    end
    checks++;
    if (z0 !== 4'b0010) begin
      errors++;
      $display("FAIL active_high_sel1: got %b want 0010", z0);
    end
    en = 1'b0;
    tick();
    checks++;
    if (z1 !== 4'b1111) begin
      errors++;
      $display("FAIL active_low_disabled: got %b want 1111", z1);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] sels [4];
    logic [3:0] exps [4];
    sels = '{2'd3, 2'd0, 2'd2, 2'd1};
    exps = '{4'b1000, 4'b0001, 4'b0100, 4'b0010};
    en = 1'b1;
    for (int i = 0; i < 4; i++) begin
      {b, a} = sels[i];
      tick();
      checks++;
      if (z0 !== exps[i]) begin
        errors++;
        $display("FAIL b2b step %0d sel=%0d: got %b want %b", i, sels[i], z0, exps[i]);
      end
    end
  endtask

  task automatic test_x_input();
    logic probe;
    bit   four_state;
    probe = 1'bx;
    four_state = (probe === 1'bx);
    en = 1'b1;
    b = 1'b0;
    a = 1'bx;
    tick();
    checks++;
    if ($isunknown(z0) || $isunknown(z1)) begin
      errors++;
      $display("FAIL x_input_no_x: got hi=%b lo=%b want no X", z0, z1);
    end
    checks++;
    if (!$onehot0(z0) || (z1 !== ~z0)) begin
      errors++;
      $display("FAIL x_input_legal: got hi=%b lo=%b want one-hot-or-zero, inverted pair", z0, z1);
    end
    if (four_state) begin
      checks++;
      if (z0 !== 4'b0000 || z1 !== 4'b1111) begin
        errors++;
        $display("FAIL x_input_inactive: got hi=%b lo=%b want 0000/1111", z0, z1);
      end
    end
    a = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    a = 1'b0;
    b = 1'b0;
    en = 1'b0;
    test_reset();
    test_sweep();
    test_latency();
    test_async_reset();
    test_active_low();
    test_back_to_back();
    test_x_input();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
